// File: rtl/dmem_sig_monitor_pkg.sv
// dmem_sig_monitor_pkg: store modes, monitor states and store hash step
package dmem_sig_monitor_pkg;
  localparam logic [1:0] MODE_B = 2'b00;
  localparam logic [1:0] MODE_H = 2'b01;
  localparam logic [1:0] MODE_W = 2'b10;
  localparam logic [1:0] MODE_R = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, PASSED, TIMEOUT} state_t;
  function automatic logic [31:0] hash_step(input logic [31:0] h, input logic [7:0] a,
                                            input logic [1:0] m, input logic [31:0] d);
    return {h[30:0], h[31]} ^ {a, 22'b0, m} ^ d;
  endfunction
endpackage

// File: rtl/dmem_sig_monitor_if.sv
// dmem_sig_monitor_if: CPU data-memory write bus
interface dmem_sig_monitor_if;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [1:0]  mode;
  logic [31:0] d_out;
  modport master(output wr_en, wr_addr, mode, d_out);
  modport slave(input wr_en, wr_addr, mode, d_out);
endinterface

// File: rtl/dmem_sig_monitor_store_lane_merge.sv
// dmem_sig_monitor_store_lane_merge: little-endian byte-lane merge of one store into a word
module dmem_sig_monitor_store_lane_merge
  import dmem_sig_monitor_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [1:0]  a,
  input  logic [1:0]  mode,
  input  logic [31:0] d_out,
  output logic [31:0] new_word,
  output logic        err
);
  always_comb begin
    err = mode == MODE_R || (mode == MODE_H && a[0]) || (mode == MODE_W && a != 2'd0);
    new_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mode == MODE_W) new_word[8*i+:8] = d_out[8*i+:8];
      else if (mode == MODE_H && i[1] == a[1]) new_word[8*i+:8] = d_out[8*(i%2)+:8];
      else if (mode == MODE_B && 2'(i) == a) new_word[8*i+:8] = d_out[7:0];
    end
  end
endmodule

// File: rtl/dmem_sig_monitor.sv
// dmem_sig_monitor: snoops data-memory stores to judge pass/timeout and capture a signature
module dmem_sig_monitor
  import dmem_sig_monitor_pkg::*;
#(
  parameter logic [7:0] PASS_ADDR      = 8'h08,
  parameter logic [7:0] SIG_BASE       = 8'h80,
  parameter int         SIG_WORDS      = 5,
  parameter int         TIMEOUT_CYCLES = 2000,
  parameter int         CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  dmem_sig_monitor_if.slave    bus,
  input  logic [3:0]           sig_idx,
  output logic [31:0]          sig_word,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycles,
  output logic [31:0]          store_hash,
  output logic                 misalign_err
);
  localparam logic [4:0] NW = 5'(SIG_WORDS);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state, state_next;
  logic [31:0] sig [16];
  logic [31:0] sig_next [16];
  logic [31:0] pass_w, pass_next, pass_new, sig_new, hash_next;
  logic [CNT_W-1:0] cycles_next;
  logic [5:0] off;
  logic [3:0] widx;
  logic err, err_p, err_s, in_win, acc, pass_hit, pass_ok, mis_next;
  dmem_sig_monitor_store_lane_merge u_pass (
    .old_word(pass_w), .a(bus.wr_addr[1:0]), .mode(bus.mode), .d_out(bus.d_out),
    .new_word(pass_new), .err(err_p)
  );
  dmem_sig_monitor_store_lane_merge u_sig (
    .old_word(sig[widx]), .a(bus.wr_addr[1:0]), .mode(bus.mode), .d_out(bus.d_out),
    .new_word(sig_new), .err(err_s)
  );
  assign err = err_p | err_s;
  assign done = state == PASSED || state == TIMEOUT;
  assign pass = state == PASSED;
  assign timeout = state == TIMEOUT;
  always_comb begin
    off = bus.wr_addr[7:2] - SIG_BASE[7:2];
    widx = off[3:0];
    in_win = off[5:4] == 2'd0 && {1'b0, widx} < NW;
    acc = state == RUN && bus.wr_en && !err;
    pass_hit = acc && bus.wr_addr[7:2] == PASS_ADDR[7:2];
    pass_ok = pass_hit && pass_new == 32'd1;
    state_next = start ? RUN : state != RUN ? state : pass_ok ? PASSED :
                 cycles == T_LAST ? TIMEOUT : RUN;
    pass_next = start ? '0 : pass_hit ? pass_new : pass_w;
    for (int i = 0; i < 16; i++)
      sig_next[i] = start ? '0 : acc && in_win && widx == 4'(i) ? sig_new : sig[i];
    cycles_next = start ? '0 : state == RUN && state_next == RUN && cycles != '1 ?
                  cycles + CNT_W'(1) : cycles;
    hash_next = start ? '0 : acc ? hash_step(store_hash, bus.wr_addr, bus.mode, bus.d_out) : store_hash;
    mis_next = !start && (misalign_err || (state == RUN && bus.wr_en && err));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pass_w <= '0;
      cycles <= '0;
      store_hash <= '0;
      misalign_err <= 1'b0;
      sig_word <= '0;
      for (int i = 0; i < 16; i++) sig[i] <= '0;
    end else begin
      state <= state_next;
      pass_w <= pass_next;
      cycles <= cycles_next;
      store_hash <= hash_next;
      misalign_err <= mis_next;
      sig_word <= {1'b0, sig_idx} < NW ? sig_next[sig_idx] : '0;
      for (int i = 0; i < 16; i++) sig[i] <= sig_next[i];
    end
  end
endmodule

// File: tb/tb_dmem_sig_monitor.sv
// tb_dmem_sig_monitor: vector table, corner sequences and random stores against a byte-memory model
module tb_dmem_sig_monitor;
  logic clk = 1'b0;
  logic rst, start;
  logic [3:0] sig_idx;
  logic [31:0] sig_word, store_hash;
  logic done, pass, timeout, misalign_err;
  logic [15:0] cycles;
  int checks = 0, errors = 0;
  dmem_sig_monitor_if bus();
  dmem_sig_monitor dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .sig_idx(sig_idx), .sig_word(sig_word),
    .done(done), .pass(pass), .timeout(timeout), .cycles(cycles), .store_hash(store_hash),
    .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [256];
  bit m_run, m_pass, m_to, m_mis;
  int m_cyc;
  logic [31:0] m_hash, m_sw;
  typedef struct packed {
    logic st, we; logic [7:0] a; logic [1:0] m; logic [31:0] d; logic [3:0] idx;
    logic [31:0] e_sig; logic e_pass, e_mis;
  } vec_t;
  vec_t tv [11];
  function automatic logic [31:0] mword(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    m_pass = 0; m_to = 0; m_cyc = 0; m_hash = 0; m_mis = 0;
  endtask
  task automatic model_update();
    bit hit;
    hit = 0;
    if (rst) begin
      clear_model(); m_run = 0; m_sw = 0;
      return;
    end
    if (start) begin
      clear_model(); m_run = 1;
    end else if (m_run) begin
      if (bus.wr_en) begin
        int a = int'(bus.wr_addr);
        int n = 1 << bus.mode;
        if (bus.mode == 2'd3 || a % n != 0) m_mis = 1;
        else begin
          for (int k = 0; k < n; k++) mem[a+k] = bus.d_out[8*k+:8];
          m_hash = ((m_hash << 1) | (m_hash >> 31)) ^ ({24'b0, bus.wr_addr} << 24) ^ {30'b0, bus.mode} ^ bus.d_out;
          hit = (a / 4 == 2) && mword(8) == 32'd1;
        end
      end
      if (hit) begin m_run = 0; m_pass = 1; end
      else if (m_cyc == 1999) begin m_run = 0; m_to = 1; end
      else m_cyc++;
    end
    m_sw = sig_idx < 4'd5 ? mword(128 + 4 * int'(sig_idx)) : 32'h0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    chk("sig_word", sig_word, m_sw);
    chk("pass", {31'b0, pass}, {31'b0, m_pass});
    chk("timeout", {31'b0, timeout}, {31'b0, m_to});
    chk("done", {31'b0, done}, {31'b0, m_pass | m_to});
    chk("cycles", {16'b0, cycles}, 32'(m_cyc));
    chk("store_hash", store_hash, m_hash);
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
  endtask
  task automatic drive(input logic st, input logic we, input logic [7:0] a, input logic [1:0] m,
                       input logic [31:0] d);
    start = st; bus.wr_en = we; bus.wr_addr = a; bus.mode = m; bus.d_out = d;
  endtask
  task automatic idle(input int n);
    drive(0, 0, 8'h00, 2'd0, 32'h0);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    tv[0]  = '{1'b1, 1'b0, 8'h00, 2'd0, 32'h0,        4'd0, 32'h0,        1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 8'h80, 2'd2, 32'hDEADBEEF, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 8'h84, 2'd0, 32'hBE,       4'd1, 32'h000000BE, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 8'h85, 2'd0, 32'hBA,       4'd1, 32'h0000BABE, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 8'h86, 2'd1, 32'hCAFE,     4'd1, 32'hCAFEBABE, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 8'h81, 2'd1, 32'h1234,     4'd0, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 1'b1, 8'h82, 2'd2, 32'h55,       4'd0, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[7]  = '{1'b0, 1'b1, 8'h80, 2'd3, 32'h77,       4'd0, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 1'b0, 8'h00, 2'd0, 32'h0,        4'd5, 32'h0,        1'b0, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 8'h08, 2'd2, 32'h1,        4'd1, 32'hCAFEBABE, 1'b1, 1'b1};
    tv[10] = '{1'b0, 1'b1, 8'h80, 2'd2, 32'h99,       4'd0, 32'hDEADBEEF, 1'b1, 1'b1};
    rst = 1; sig_idx = 0;
    drive(1, 1, 8'h80, 2'd2, 32'h12345678);
    step();
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_hash", store_hash, 32'h0);
    rst = 0;
    drive(0, 1, 8'h80, 2'd2, 32'h12345678);
    step();
    chk("idle_store_sig", sig_word, 32'h0);
    chk("idle_store_hash", store_hash, 32'h0);
    for (int i = 0; i < 11; i++) begin
      drive(tv[i].st, tv[i].we, tv[i].a, tv[i].m, tv[i].d);
      sig_idx = tv[i].idx;
      step();
      chk($sformatf("tv%0d_sig", i), sig_word, tv[i].e_sig);
      chk($sformatf("tv%0d_pass", i), {31'b0, pass}, {31'b0, tv[i].e_pass});
      chk($sformatf("tv%0d_mis", i), {31'b0, misalign_err}, {31'b0, tv[i].e_mis});
    end
    sig_idx = 0;
    drive(1, 0, 8'h00, 2'd0, 32'h0);
    step();
    chk("rearm_pass", {31'b0, pass}, 32'h0);
    chk("rearm_sig", sig_word, 32'h0);
    chk("rearm_cycles", {16'b0, cycles}, 32'h0);
    drive(0, 1, 8'h08, 2'd2, 32'h2);
    step();
    idle(3);
    chk("pass_not1_run", {31'b0, done}, 32'h0);
    drive(0, 1, 8'h08, 2'd2, 32'h1);
    step();
    chk("pass_fixed", {31'b0, pass}, 32'h1);
    drive(1, 0, 8'h00, 2'd0, 32'h0);
    step();
    idle(1999);
    chk("to_before", {31'b0, timeout}, 32'h0);
    chk("to_cycles_last", {16'b0, cycles}, 32'd1999);
    step();
    chk("to_flag", {31'b0, timeout}, 32'h1);
    chk("to_pass", {31'b0, pass}, 32'h0);
    idle(3);
    chk("to_frozen", {16'b0, cycles}, 32'd1999);
    drive(1, 0, 8'h00, 2'd0, 32'h0);
    step();
    idle(1999);
    drive(0, 1, 8'h08, 2'd2, 32'h1);
    step();
    chk("last_cycle_pass", {31'b0, pass}, 32'h1);
    chk("last_cycle_not_to", {31'b0, timeout}, 32'h0);
    drive(1, 0, 8'h00, 2'd0, 32'h0);
    step();
    drive(0, 1, 8'h84, 2'd2, 32'hA5A5A5A5);
    step();
    rst = 1;
    drive(0, 0, 8'h00, 2'd0, 32'h0);
    sig_idx = 1;
    step();
    rst = 0;
    chk("rst_run_hash", store_hash, 32'h0);
    chk("rst_run_sig", sig_word, 32'h0);
    step();
    chk("rst_run_idle_cycles", {16'b0, cycles}, 32'h0);
    for (int i = 0; i < 600; i++) begin
      int r = int'($urandom_range(0, 3));
      logic [7:0] a;
      a = r == 0 ? 8'h08 + 8'($urandom_range(0, 3)) : r == 3 ? 8'($urandom) : 8'h80 + 8'($urandom_range(0, 23));
      rst = $urandom_range(0, 199) == 0;
      drive($urandom_range(0, 49) == 0 || i == 0, 1'($urandom), a, 2'($urandom),
            $urandom_range(0, 3) == 0 ? 32'h1 : $urandom);
      sig_idx = 4'($urandom_range(0, 7));
      step();
    end
    rst = 0;
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
